// File: rtl/delay_pulse_array_if.sv
// Signal bundle for delay_pulse_array: triggers, config write port, overrun clear,
// per-channel status and the optional pulse-counter readout.
interface delay_pulse_array_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16
);
    logic [CHANNELS-1:0] trig;
    logic                cfg_we;
    logic [3:0]          cfg_ch;
    logic [CNT_W-1:0]    cfg_delay;
    logic [CNT_W-1:0]    cfg_width;
    logic                cfg_retrig;
    logic                ovr_clr;
    logic [CHANNELS-1:0] pulse_out;
    logic [CHANNELS-1:0] busy;
    logic [CHANNELS-1:0] overrun;
    logic [3:0]          cnt_sel;
    logic                cnt_clr;
    logic [15:0]         cnt_data;

    modport master (
        output trig, cfg_we, cfg_ch, cfg_delay, cfg_width, cfg_retrig, ovr_clr,
        output cnt_sel, cnt_clr,
        input  pulse_out, busy, overrun, cnt_data
    );

    modport slave (
        input  trig, cfg_we, cfg_ch, cfg_delay, cfg_width, cfg_retrig, ovr_clr,
        input  cnt_sel, cnt_clr,
        output pulse_out, busy, overrun, cnt_data
    );
endinterface

// File: rtl/delay_pulse_array.sv
// Multi-channel edge-triggered delayed pulse generator with retrigger and sticky overrun.
// Optional per-channel pulse counters are enabled with macro DELAY_PULSE_COUNT_EN.
module delay_pulse_array #(
    parameter int CHANNELS      = 4,
    parameter int CNT_W         = 16,
    parameter int DEFAULT_DELAY = 5,
    parameter int DEFAULT_WIDTH = 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    delay_pulse_array_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PULSE = 2'd2
    } state_t;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_ZERO  = {CNT_W{1'b0}};
    localparam cnt_t CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam cnt_t DEF_DELAY = CNT_W'(DEFAULT_DELAY);
    localparam cnt_t DEF_WIDTH = CNT_W'(DEFAULT_WIDTH);

    function automatic cnt_t width_m1(input cnt_t wid);
        width_m1 = (wid == CNT_ZERO) ? CNT_ZERO : (wid - CNT_ONE);
    endfunction

    // Packed {state, count} for a sequence (re)started with the given delay and width.
    function automatic logic [CNT_W+1:0] launch(input cnt_t dly, input cnt_t wid);
        if (dly != CNT_ZERO) begin
            launch = {ST_DELAY, dly - CNT_ONE};
        end else begin
            launch = {ST_PULSE, width_m1(wid)};
        end
    endfunction

    function automatic logic [CNT_W+1:0] advance(input state_t st, input cnt_t cnt, input cnt_t wid);
        case (st)
            ST_DELAY: advance = (cnt == CNT_ZERO) ? {ST_PULSE, width_m1(wid)} : {ST_DELAY, cnt - CNT_ONE};
            ST_PULSE: advance = (cnt == CNT_ZERO) ? {ST_IDLE, CNT_ZERO} : {ST_PULSE, cnt - CNT_ONE};
            default:  advance = {ST_IDLE, CNT_ZERO};
        endcase
    endfunction

    logic [CHANNELS-1:0] trig_q;
    logic [CHANNELS-1:0] edge_q;
    logic [CHANNELS-1:0] edge_d;
    state_t              state_q [CHANNELS];
    state_t              state_d [CHANNELS];
    cnt_t                cnt_q [CHANNELS];
    cnt_t                cnt_d [CHANNELS];
    cnt_t                sh_delay_q [CHANNELS];
    cnt_t                sh_delay_d [CHANNELS];
    cnt_t                sh_width_q [CHANNELS];
    cnt_t                sh_width_d [CHANNELS];
    cnt_t                wk_delay_q [CHANNELS];
    cnt_t                wk_delay_d [CHANNELS];
    cnt_t                wk_width_q [CHANNELS];
    cnt_t                wk_width_d [CHANNELS];
    logic [CHANNELS-1:0] sh_retrig_q;
    logic [CHANNELS-1:0] sh_retrig_d;
    logic [CHANNELS-1:0] wk_retrig_q;
    logic [CHANNELS-1:0] wk_retrig_d;
    logic [CHANNELS-1:0] pulse_q;
    logic [CHANNELS-1:0] pulse_d;
    logic [CHANNELS-1:0] busy_q;
    logic [CHANNELS-1:0] busy_d;
    logic [CHANNELS-1:0] ovr_q;
    logic [CHANNELS-1:0] ovr_d;
    logic [CHANNELS-1:0] cfg_hit_s;
    logic [CHANNELS-1:0] start_s;
    logic [CNT_W+1:0]    nxt_s [CHANNELS];

    // Per-channel config shadowing, sequence FSM next state and overrun flags.
    always_comb begin
        edge_d = bus.trig & ~trig_q;
        for (int i = 0; i < CHANNELS; i++) begin
            cfg_hit_s[i]   = bus.cfg_we && (bus.cfg_ch == 4'(i));
            sh_delay_d[i]  = cfg_hit_s[i] ? bus.cfg_delay  : sh_delay_q[i];
            sh_width_d[i]  = cfg_hit_s[i] ? bus.cfg_width  : sh_width_q[i];
            sh_retrig_d[i] = cfg_hit_s[i] ? bus.cfg_retrig : sh_retrig_q[i];
            wk_delay_d[i]  = wk_delay_q[i];
            wk_width_d[i]  = wk_width_q[i];
            wk_retrig_d[i] = wk_retrig_q[i];
            ovr_d[i]       = bus.ovr_clr ? 1'b0 : ovr_q[i];
            nxt_s[i]       = {state_q[i], cnt_q[i]};
            case (state_q[i])
                ST_IDLE: begin
                    if (edge_q[i]) begin
                        wk_delay_d[i]  = sh_delay_q[i];
                        wk_width_d[i]  = sh_width_q[i];
                        wk_retrig_d[i] = sh_retrig_q[i];
                        nxt_s[i]       = launch(sh_delay_q[i], sh_width_q[i]);
                    end else begin
                        nxt_s[i] = {ST_IDLE, CNT_ZERO};
                    end
                end
                ST_DELAY, ST_PULSE: begin
                    if (edge_q[i] && wk_retrig_q[i]) begin
                        nxt_s[i] = launch(wk_delay_q[i], wk_width_q[i]);
                    end else begin
                        // An ignored edge sets the flag even when ovr_clr is asserted.
                        ovr_d[i] = ovr_d[i] | edge_q[i];
                        nxt_s[i] = advance(state_q[i], cnt_q[i], wk_width_q[i]);
                    end
                end
                default: begin
                    nxt_s[i] = {ST_IDLE, CNT_ZERO};
                end
            endcase
            state_d[i] = state_t'(nxt_s[i][CNT_W+1:CNT_W]);
            cnt_d[i]   = nxt_s[i][CNT_W-1:0];
            pulse_d[i] = (state_d[i] == ST_PULSE);
            busy_d[i]  = (state_d[i] != ST_IDLE);
            start_s[i] = pulse_d[i] && (state_q[i] != ST_PULSE);
        end
    end

    // State, counters, config and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            trig_q      <= {CHANNELS{1'b1}};
            edge_q      <= {CHANNELS{1'b0}};
            sh_retrig_q <= {CHANNELS{1'b0}};
            wk_retrig_q <= {CHANNELS{1'b0}};
            pulse_q     <= {CHANNELS{1'b0}};
            busy_q      <= {CHANNELS{1'b0}};
            ovr_q       <= {CHANNELS{1'b0}};
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]    <= ST_IDLE;
                cnt_q[i]      <= CNT_ZERO;
                sh_delay_q[i] <= DEF_DELAY;
                sh_width_q[i] <= DEF_WIDTH;
                wk_delay_q[i] <= DEF_DELAY;
                wk_width_q[i] <= DEF_WIDTH;
            end
        end else begin
            trig_q      <= bus.trig;
            edge_q      <= edge_d;
            sh_retrig_q <= sh_retrig_d;
            wk_retrig_q <= wk_retrig_d;
            pulse_q     <= pulse_d;
            busy_q      <= busy_d;
            ovr_q       <= ovr_d;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]    <= state_d[i];
                cnt_q[i]      <= cnt_d[i];
                sh_delay_q[i] <= sh_delay_d[i];
                sh_width_q[i] <= sh_width_d[i];
                wk_delay_q[i] <= wk_delay_d[i];
                wk_width_q[i] <= wk_width_d[i];
            end
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = ovr_q;

`ifdef DELAY_PULSE_COUNT_EN
    logic [15:0] evt_cnt_q [CHANNELS];
    logic [15:0] evt_cnt_d [CHANNELS];
    logic [15:0] cnt_data_q;
    logic [15:0] cnt_data_d;

    // Saturating pulse-start counters; a clear overrides a same-cycle increment.
    always_comb begin
        cnt_data_d = 16'h0000;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.cnt_clr) begin
                evt_cnt_d[i] = 16'h0000;
            end else if (start_s[i] && (evt_cnt_q[i] != 16'hFFFF)) begin
                evt_cnt_d[i] = evt_cnt_q[i] + 16'd1;
            end else begin
                evt_cnt_d[i] = evt_cnt_q[i];
            end
            cnt_data_d = (bus.cnt_sel == 4'(i)) ? evt_cnt_q[i] : cnt_data_d;
        end
    end

    // Counter storage and registered readout.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_data_q <= 16'h0000;
            for (int i = 0; i < CHANNELS; i++) begin
                evt_cnt_q[i] <= 16'h0000;
            end
        end else begin
            cnt_data_q <= cnt_data_d;
            for (int i = 0; i < CHANNELS; i++) begin
                evt_cnt_q[i] <= evt_cnt_d[i];
            end
        end
    end

    assign bus.cnt_data = cnt_data_q;
`else
    logic unused_cnt_s;
    assign unused_cnt_s = ^{bus.cnt_sel, bus.cnt_clr, start_s};
    assign bus.cnt_data = 16'h0000;
`endif

endmodule

// File: doc/delay_pulse_array.md
Name: delay_pulse_array

Overview:
Multi-channel successor to the single-shot trigger delay.
- Each of CHANNELS independent channels detects a rising edge on its trigger input and waits a runtime-programmable number of clocks.
- It then emits a pulse of programmable width on pulse_out.
- Per-channel retrigger mode and a sticky overrun flag are added.
- Sits between debounced button/virtual-interface inputs and LED/actuator drivers.

Parameters:
CHANNELS, 4, number of independent channels (1..16)
CNT_W, 16, width of delay/width counters and config fields
DEFAULT_DELAY, 5, per-channel delay loaded at reset
DEFAULT_WIDTH, 1, per-channel pulse width loaded at reset

Ports:
CLK  in  1  sole clock, all logic on posedge
RST_N  in  1  synchronous, active-low reset
trig  in  CHANNELS  per-channel trigger, synchronous to CLK
cfg_we  in  1  config write strobe, one cycle
cfg_ch  in  4  target channel for write
cfg_delay  in  CNT_W  delay in clocks
cfg_width  in  CNT_W  pulse width in clocks (0 treated as 1)
cfg_retrig  in  1  1 = edge during active sequence restarts delay
ovr_clr  in  1  clears all overrun flags
pulse_out  out  CHANNELS  registered delayed pulses
busy  out  CHANNELS  channel in DELAY or PULSE
overrun  out  CHANNELS  sticky: edge ignored while busy

Behaviour:
- Reset (RST_N low at a posedge):
  - pulse_out, busy and overrun go to 0; all channels return to IDLE.
  - Config returns to DEFAULT_DELAY / DEFAULT_WIDTH / retrig=0.
  - The trig history register is set to all-ones, so a trigger held high through reset exit does not fire.
  - Reset mid-sequence aborts the sequence immediately.
- Edge detect: edge[i] = trig[i] & ~trig_q[i]. trig_q is the previous-cycle sample.
- Config:
  - On cfg_we with cfg_ch < CHANNELS, the channel's shadow delay/width/retrig are written.
  - cfg_ch >= CHANNELS: write ignored.
  - An accepted edge snapshots the shadow registers into working registers, so writes never disturb a running sequence.
- Per-channel FSM states IDLE, DELAY, PULSE:
  - IDLE: on edge, latch config.
    - delay > 0: go to DELAY with cnt = delay - 1.
    - delay = 0: go to PULSE with cnt = max(width,1) - 1.
  - DELAY: if cnt == 0, go to PULSE with cnt = max(width,1) - 1; else cnt decrements.
  - PULSE: pulse_out = 1. If cnt == 0, go to IDLE; else cnt decrements.
- Latency:
  - Edge sampled at posedge t: pulse_out rises at posedge t+1+delay and stays high exactly max(width,1) cycles.
  - delay=5, width=1 reproduces the legacy single-channel timing.
- busy = (state != IDLE), registered together with the state.
- Edge while busy:
  - retrig=1: reload DELAY from the working delay; pulse_out drops next cycle if it was in PULSE; overrun unchanged.
  - retrig=0: edge ignored and overrun[i] set.
- Edge on the final PULSE cycle counts as "while busy" and follows the rules above; no back-to-back chaining.
- overrun:
  - ovr_clr clears all flags.
  - If an ignored edge and ovr_clr coincide, the set wins.
- Channels are fully independent; simultaneous edges on all channels are legal.

Optional Feature:
Macro: DELAY_PULSE_COUNT_EN
- Defined:
  - Adds inputs cnt_sel (4 bits) and cnt_clr.
  - Adds output cnt_data (16 bits): the registered, saturating (stops at 0xFFFF) count of pulses started on channel cnt_sel, one cycle read latency.
  - A count increments on each IDLE/DELAY to PULSE transition.
  - cnt_clr zeroes all counts; it takes priority over an increment in the same cycle.
- Undefined: the ports still exist (cnt_data tied to 0, inputs ignored), so instantiations are unchanged.

Test Plan:
- Reset defaults: trig[0] 0->1 at cycle 10 -> pulse_out[0] high cycle 16 only; busy[0] high cycles 11-16.
- Program ch1 delay=0, width=3; trig[1] edge at cycle 20 -> pulse_out[1] high cycles 21-23; other channels stay idle.
- ch2 retrig=0, delay=10; second edge 4 cycles after first -> overrun[2]=1, pulse timing unchanged. ovr_clr -> overrun[2]=0.
- ch3 retrig=1, delay=8; second edge 5 cycles after first -> pulse at second edge +9, only one pulse emitted.
- Hold trig[0]=1 across RST_N deassert -> no pulse. cfg_we to ch2 mid-DELAY -> current pulse uses the old config, next trigger uses the new one. RST_N low mid-PULSE -> pulse_out 0 next cycle.
- DELAY_PULSE_COUNT_EN: 3 triggers on ch0, cnt_sel=0 -> cnt_data=3 one cycle later; cnt_clr -> 0.
